// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BTB-based branch prediction, EX resolution, redirect and halt drain
module branch_predict_unit #(
   parameter int PC_W        = 9,
   parameter int BTB_ENTRIES = 16,
   parameter int CTR_W       = 2,
   parameter int HALT_DRAIN  = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   input  logic              ex_valid,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic [31:0]       Imm,
   input  logic              Branch,
   input  logic [31:0]       AluResult,
   input  logic              jal,
   input  logic              jalr,
   input  logic [31:0]       jalr_src,
   input  logic              ex_pred_taken,
   input  logic [PC_W-1:0]   ex_pred_target,
   input  logic              halt,
   output logic              PcSel,
   output logic [31:0]       BrPC,
   output logic              halted,
   output logic [CNT_W-1:0]  mispredicts
);

   localparam int IDX_W  = $clog2(BTB_ENTRIES);
   localparam int TAG_W  = PC_W - IDX_W - 2;
   localparam int DCNT_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
   localparam logic [CTR_W-1:0]  CTR_WEAK   = CTR_W'(1 << (CTR_W - 1));
   localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(HALT_DRAIN - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_HALTED} state_t;

   logic             btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
   logic [PC_W-1:0]  btb_target [BTB_ENTRIES];
   logic [CTR_W-1:0] btb_ctr    [BTB_ENTRIES];

   state_t            state;
   logic [DCNT_W-1:0] drain_cnt;

   logic [IDX_W-1:0] f_idx, e_idx;
   logic [TAG_W-1:0] f_tag, e_tag;
   logic             f_hit, e_hit;
   logic             actual_taken, mispredict, upd_en;
   logic [31:0]      ex_pc_ext, actual_target, ex_pc_plus4;
   logic             unused_ok;

   assign f_idx = fetch_pc[IDX_W+1:2];
   assign f_tag = fetch_pc[PC_W-1:IDX_W+2];
   assign e_idx = ex_pc[IDX_W+1:2];
   assign e_tag = ex_pc[PC_W-1:IDX_W+2];

   assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
   assign pred_taken  = f_hit && btb_ctr[f_idx][CTR_W-1];
   assign pred_target = pred_taken ? btb_target[f_idx] : '0;

   assign ex_pc_ext     = {{(32-PC_W){1'b0}}, ex_pc};
   assign ex_pc_plus4   = ex_pc_ext + 32'd4;
   assign actual_taken  = (Branch && AluResult[0]) || jal || jalr;
   assign actual_target = jalr ? jalr_src : (ex_pc_ext + Imm);

   assign mispredict = ex_valid && ((actual_taken != ex_pred_taken) ||
                       (actual_taken && (ex_pred_target != actual_target[PC_W-1:0])));
   assign PcSel = mispredict;
   assign BrPC  = mispredict ? (actual_taken ? actual_target : ex_pc_plus4) : 32'd0;

   // jalr targets are register-dependent, so they never enter the table
   assign e_hit  = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
   assign upd_en = ex_valid && (Branch || jal) && (state != S_HALTED);

   assign unused_ok = ^{fetch_pc[1:0], AluResult[31:1]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i] <= 1'b0;
            btb_ctr[i]   <= '0;
         end
      end else if (upd_en) begin
         if (e_hit) begin
            if (actual_taken) begin
               if (btb_ctr[e_idx] != '1)
                  btb_ctr[e_idx] <= btb_ctr[e_idx] + CTR_W'(1);
            end else if (btb_ctr[e_idx] != '0) begin
               btb_ctr[e_idx] <= btb_ctr[e_idx] - CTR_W'(1);
            end
         end else if (actual_taken) begin
            btb_valid[e_idx] <= 1'b1;
            btb_ctr[e_idx]   <= jal ? '1 : CTR_WEAK;
         end
      end
   end

   // Tag/target are qualified by valid, so they need no reset
   always_ff @(posedge clk) begin
      if (upd_en && actual_taken) begin
         btb_tag[e_idx]    <= e_tag;
         btb_target[e_idx] <= actual_target[PC_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         mispredicts <= '0;
      else if (mispredict && (state != S_HALTED) && (mispredicts != '1))
         mispredicts <= mispredicts + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         drain_cnt <= '0;
         halted    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ex_valid && halt && !mispredict) begin
                  state     <= S_DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == '0) begin
                  state  <= S_HALTED;
                  halted <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DCNT_W'(1);
               end
            end
            default: begin
               state  <= S_HALTED;
               halted <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [8:0]  fetch_pc;
   logic        pred_taken;
   logic [8:0]  pred_target;
   logic        ex_valid;
   logic [8:0]  ex_pc;
   logic [31:0] Imm;
   logic        Branch;
   logic [31:0] AluResult;
   logic        jal;
   logic        jalr;
   logic [31:0] jalr_src;
   logic        ex_pred_taken;
   logic [8:0]  ex_pred_target;
   logic        halt;
   logic        PcSel;
   logic [31:0] BrPC;
   logic        halted;
   logic [15:0] mispredicts;

   int tests = 0;
   int fails = 0;

   branch_predict_unit #(
      .PC_W(9), .BTB_ENTRIES(16), .CTR_W(2), .HALT_DRAIN(2), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc), .Imm(Imm),
      .Branch(Branch), .AluResult(AluResult), .jal(jal), .jalr(jalr),
      .jalr_src(jalr_src), .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target), .halt(halt), .PcSel(PcSel), .BrPC(BrPC),
      .halted(halted), .mispredicts(mispredicts)
   );

   always #5 clk = ~clk;

   task automatic clear_ex();
      ex_valid = 0; ex_pc = 0; Imm = 0; Branch = 0; AluResult = 0; jal = 0;
      jalr = 0; jalr_src = 0; ex_pred_taken = 0; ex_pred_target = 0; halt = 0;
   endtask

   // Drive one EX instruction; inputs change just after a falling edge
   task automatic drive_ex(input logic br, input logic cond, input logic j, input logic jr,
                           input logic [8:0] pc, input logic [31:0] imm, input logic [31:0] src,
                           input logic ptk, input logic [8:0] ptgt);
      ex_valid = 1; Branch = br; AluResult = {31'd0, cond}; jal = j; jalr = jr;
      ex_pc = pc; Imm = imm; jalr_src = src; ex_pred_taken = ptk; ex_pred_target = ptgt;
      halt = 0;
      #1;
   endtask

   task automatic test_reset();
      clear_ex(); fetch_pc = 9'h10;
      reset = 0;
      #1;
      tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred_taken got %b exp 0", pred_taken); end
      tests++; if (pred_target !== 9'h0) begin fails++; $display("FAIL reset_pred_target got %h exp 0", pred_target); end
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", halted); end
      tests++; if (mispredicts !== 16'd0) begin fails++; $display("FAIL reset_mispredicts got %0d exp 0", mispredicts); end
      @(negedge clk); reset = 1;
   endtask

   task automatic test_first_branch();
      drive_ex(1, 1, 0, 0, 9'h10, 32'h20, 0, 0, 9'h0);
      tests++; if (PcSel !== 1'b1) begin fails++; $display("FAIL beq1_pcsel got %b exp 1", PcSel); end
      tests++; if (BrPC !== 32'h30) begin fails++; $display("FAIL beq1_brpc got %h exp 30", BrPC); end
      @(negedge clk); clear_ex(); fetch_pc = 9'h10; #1;
      tests++; if (mispredicts !== 16'd1) begin fails++; $display("FAIL beq1_count got %0d exp 1", mispredicts); end
      tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL beq1_pred got %b exp 1", pred_taken); end
      tests++; if (pred_target !== 9'h30) begin fails++; $display("FAIL beq1_target got %h exp 30", pred_target); end
   endtask

   task automatic test_counter();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); drive_ex(1, 1, 0, 0, 9'h10, 32'h20, 0, 1, 9'h30);
         tests++; if (PcSel !== 1'b0) begin fails++; $display("FAIL ctr_taken%0d_pcsel got %b exp 0", i, PcSel); end
      end
      @(negedge clk); drive_ex(1, 0, 0, 0, 9'h10, 32'h20, 0, 1, 9'h30);
      tests++; if (PcSel !== 1'b1) begin fails++; $display("FAIL ctr_nt_pcsel got %b exp 1", PcSel); end
      tests++; if (BrPC !== 32'h14) begin fails++; $display("FAIL ctr_nt_brpc got %h exp 14", BrPC); end
      @(negedge clk); clear_ex(); fetch_pc = 9'h10; #1;
      tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL ctr_weak_pred got %b exp 1", pred_taken); end
      tests++; if (mispredicts !== 16'd2) begin fails++; $display("FAIL ctr_count got %0d exp 2", mispredicts); end
      @(negedge clk); drive_ex(1, 0, 0, 0, 9'h10, 32'h20, 0, 1, 9'h30);
      @(negedge clk); clear_ex(); fetch_pc = 9'h10; #1;
      tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL ctr_wnt_pred got %b exp 0", pred_taken); end
      tests++; if (pred_target !== 9'h0) begin fails++; $display("FAIL ctr_wnt_target got %h exp 0", pred_target); end
      tests++; if (mispredicts !== 16'd3) begin fails++; $display("FAIL ctr_count2 got %0d exp 3", mispredicts); end
   endtask

   task automatic test_jal();
      @(negedge clk); drive_ex(0, 0, 1, 0, 9'h40, 32'hFFFF_FFF8, 0, 0, 9'h0);
      tests++; if (PcSel !== 1'b1) begin fails++; $display("FAIL jal1_pcsel got %b exp 1", PcSel); end
      tests++; if (BrPC !== 32'h38) begin fails++; $display("FAIL jal1_brpc got %h exp 38", BrPC); end
      @(negedge clk); clear_ex(); fetch_pc = 9'h40; #1;
      tests++; if (pred_target !== 9'h38) begin fails++; $display("FAIL jal_pred_target got %h exp 38", pred_target); end
      drive_ex(0, 0, 1, 0, 9'h40, 32'hFFFF_FFF8, 0, 1, 9'h38);
      tests++; if (PcSel !== 1'b0) begin fails++; $display("FAIL jal2_pcsel got %b exp 0", PcSel); end
      tests++; if (BrPC !== 32'h0) begin fails++; $display("FAIL jal2_brpc got %h exp 0", BrPC); end
      @(negedge clk); clear_ex(); #1;
      tests++; if (mispredicts !== 16'd4) begin fails++; $display("FAIL jal_count got %0d exp 4", mispredicts); end
   endtask

   task automatic test_jalr();
      drive_ex(0, 0, 0, 1, 9'h20, 32'h4, 32'h80, 0, 9'h0);
      tests++; if (PcSel !== 1'b1) begin fails++; $display("FAIL jalr_pcsel got %b exp 1", PcSel); end
      tests++; if (BrPC !== 32'h80) begin fails++; $display("FAIL jalr_brpc got %h exp 80", BrPC); end
      @(negedge clk); clear_ex(); fetch_pc = 9'h20; #1;
      tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL jalr_no_alloc got %b exp 0", pred_taken); end
      tests++; if (mispredicts !== 16'd5) begin fails++; $display("FAIL jalr_count got %0d exp 5", mispredicts); end
   endtask

   task automatic test_alias();
      drive_ex(1, 1, 0, 0, 9'h10, 32'h20, 0, 0, 9'h0);
      @(negedge clk);
      drive_ex(1, 1, 0, 0, 9'h50, 32'h10, 0, 0, 9'h0);
      fetch_pc = 9'h50; #1;
      tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL alias_war_pred got %b exp 0", pred_taken); end
      tests++; if (BrPC !== 32'h60) begin fails++; $display("FAIL alias_brpc got %h exp 60", BrPC); end
      @(negedge clk); clear_ex(); fetch_pc = 9'h10; #1;
      tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL alias_old_pred got %b exp 0", pred_taken); end
      fetch_pc = 9'h50; #1;
      tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL alias_new_pred got %b exp 1", pred_taken); end
      tests++; if (pred_target !== 9'h60) begin fails++; $display("FAIL alias_new_target got %h exp 60", pred_target); end
      tests++; if (mispredicts !== 16'd7) begin fails++; $display("FAIL alias_count got %0d exp 7", mispredicts); end
   endtask

   task automatic test_halt();
      clear_ex(); ex_valid = 1; halt = 1;
      @(negedge clk);
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_e1 got %b exp 0", halted); end
      @(negedge clk);
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_e2 got %b exp 0 (second halt)", halted); end
      clear_ex();
      @(negedge clk);
      tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_e3 got %b exp 1", halted); end
      drive_ex(1, 1, 0, 0, 9'h20, 32'h8, 0, 0, 9'h0);
      tests++; if (PcSel !== 1'b1) begin fails++; $display("FAIL halted_pcsel got %b exp 1", PcSel); end
      @(negedge clk); clear_ex(); fetch_pc = 9'h20; #1;
      tests++; if (mispredicts !== 16'd7) begin fails++; $display("FAIL halted_count_frozen got %0d exp 7", mispredicts); end
      tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL halted_table_frozen got %b exp 0", pred_taken); end
      tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halted_sticky got %b exp 1", halted); end
   endtask

   task automatic test_reset_mid_drain();
      @(negedge clk); reset = 0; #1;
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst2_halted got %b exp 0", halted); end
      tests++; if (mispredicts !== 16'd0) begin fails++; $display("FAIL rst2_count got %0d exp 0", mispredicts); end
      fetch_pc = 9'h50; #1;
      tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL rst2_table got %b exp 0", pred_taken); end
      @(negedge clk); reset = 1;
      ex_valid = 1; halt = 1;
      @(negedge clk); clear_ex();
      #2 reset = 0;
      #1;
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL middrain_halted got %b exp 0", halted); end
      @(negedge clk); reset = 1;
      repeat (4) @(negedge clk);
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL middrain_idle got %b exp 0", halted); end
   endtask

   initial begin
      test_reset();
      test_first_branch();
      test_counter();
      test_jal();
      test_jalr();
      test_alias();
      test_halt();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the processor's branch resolution logic. Adds a direct-mapped branch target buffer with saturating direction counters, so fetch can predict taken branches and jal. Resolves the actual outcome in EX, raises a redirect/flush only on a misprediction, and updates the table. Also provides a cycle-accurate, synthesizable halt drain (sticky halted flag) and a misprediction counter.

Parameters:
PC_W, 9, PC width in bits (byte address)
BTB_ENTRIES, 16, table entries; power of two, ≥2
CTR_W, 2, direction counter width
HALT_DRAIN, 2, cycles between accepted halt and halted assertion (≥1)
CNT_W, 16, misprediction counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
fetch_pc  in  PC_W  PC being fetched this cycle
pred_taken  out  1  fetch prediction: taken
pred_target  out  PC_W  predicted target (0 when pred_taken=0)
ex_valid  in  1  EX holds a real instruction (not bubble/flushed)
ex_pc  in  PC_W  PC of the EX instruction
Imm  in  32  sign-extended immediate
Branch  in  1  conditional branch in EX
AluResult  in  32  bit 0 = condition true
jal  in  1  EX instruction is jal
jalr  in  1  EX instruction is jalr
jalr_src  in  32  rs1+imm for jalr
ex_pred_taken  in  1  prediction carried down the pipe with this instruction
ex_pred_target  in  PC_W  predicted target carried down the pipe
halt  in  1  EX instruction is halt
PcSel  out  1  redirect fetch to BrPC and flush younger stages
BrPC  out  32  correct next PC on redirect, else 0
halted  out  1  sticky, processor stopped
mispredicts  out  CNT_W  saturating misprediction count

Behaviour:
- IDX_W = log2(BTB_ENTRIES). Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. Entry = {valid, tag, target[PC_W-1:0], ctr[CTR_W-1:0]}.
- Prediction (combinational from registered state): hit = valid && tag match. pred_taken = hit && ctr MSB; pred_target = pred_taken ? target : 0.
- Resolution (combinational):
  - actual_taken = (Branch && AluResult[0]) || jal || jalr.
  - actual_target = jalr ? jalr_src : {zero-ext ex_pc} + Imm, 32-bit wrap.
  - ex_pc+4 is computed in 32 bits after zero-extending ex_pc.
- mispredict = ex_valid && (actual_taken != ex_pred_taken || (actual_taken && ex_pred_target != actual_target[PC_W-1:0])).
- PcSel = mispredict. BrPC = mispredict ? (actual_taken ? actual_target : ex_pc+4) : 0. Zero added latency: same-cycle outputs.
- Table update (on clk edge, only when ex_valid && (Branch || jal)); jalr never allocates or updates:
  - Hit and taken: ctr saturating +1, target ← actual_target[PC_W-1:0].
  - Hit and not taken: ctr saturating −1; target unchanged.
  - Miss and taken: allocate/overwrite entry with valid=1, new tag, target, ctr = 2^(CTR_W-1) (weakly taken); jal allocates ctr = all ones.
  - Miss and not taken: no change.
- Same-index read/write in one cycle: fetch sees pre-update contents (write-after-read).
- mispredicts increments on each clock with mispredict=1, saturating at all ones.
- Halt FSM, states IDLE → DRAIN → HALTED:
  - IDLE → DRAIN on ex_valid && halt && !mispredict; load drain counter with HALT_DRAIN-1.
  - DRAIN decrements each cycle; → HALTED when counter = 0 at a clock edge.
  - halted = (state == HALTED), sticky until reset.
  - Further halt inputs are ignored in DRAIN and HALTED.
  - Table updates and the mispredicts counter freeze in HALTED.
- Reset (asynchronous, any time, including mid-DRAIN): all valid bits and ctrs = 0, mispredicts = 0, state = IDLE.
  - Outputs then: pred_taken=0, pred_target=0, halted=0. PcSel/BrPC follow the combinational inputs.
- No $stop or simulation-only constructs; halting is signalled only via halted.

Test Plan:
1. Reset, then beq at ex_pc=0x10, Imm=0x20, AluResult=1, ex_pred_taken=0 → PcSel=1, BrPC=0x30, mispredicts=1. Next cycle fetch_pc=0x10 → pred_taken=1, pred_target=0x30.
2. Repeat the taken beq at 0x10 twice, then not-taken with ex_pred_taken=1 → PcSel=1, BrPC=0x14. Ctr goes 10→11→11→10; prediction stays taken.
3. jal at 0x40, Imm=−8, first time → redirect to 0x38. Second time with ex_pred_taken=1, ex_pred_target=0x38 → PcSel=0.
4. jalr with jalr_src=0x80 and ex_pred_taken=0 → PcSel=1, BrPC=0x80, table unchanged (fetch_pc = that PC gives pred_taken=0).
5. Aliasing: taken branch at 0x10, then a taken branch at 0x50 with BTB_ENTRIES=16 (same index, different tag) → entry overwritten; fetch_pc=0x10 then gives pred_taken=0.
6. halt with ex_valid=1, HALT_DRAIN=2 → halted=1 exactly 2 edges later; second halt ignored. Assert reset mid-DRAIN → halted stays 0 and the FSM is in IDLE.
